crc_ahb_engine: RTL and testbench
=================================

Name: crc_ahb_engine

Overview:
- Consumes the synchronised register set (data address, CRC address, length, ready flag) from the HCLK-domain request synchroniser.
- On each new ready event, acts as a single-transfer AHB-Lite master: reads DLEN+1 words starting at the data address and folds each into a running CRC.
- Writes the final CRC word to the CRC address, then pulses done.

Parameters:
- DATA_WIDTH, 16, bus word width and CRC width
- ADDR_WIDTH, 6, word address width
- CRC_POLY, 16'h1021, generator polynomial, implicit x^DATA_WIDTH term
- CRC_INIT, 16'hFFFF, CRC seed loaded at job start

Ports:
- HCLK  in  1  system clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- regs_ready  in  1  level from synchroniser; a job starts on its rising edge
- dadr  in  ADDR_WIDTH  first data word address
- cadr  in  ADDR_WIDTH  CRC result write address
- dlen  in  2  word count minus 1 (1..4 words)
- HADDR  out  ADDR_WIDTH  AHB address
- HTRANS  out  2  AHB transfer type, IDLE=2'b00 or NONSEQ=2'b10 only
- HWRITE  out  1  AHB write strobe
- HWDATA  out  DATA_WIDTH  AHB write data
- HRDATA  in  DATA_WIDTH  AHB read data
- HREADY  in  1  AHB transfer-complete / wait
- busy  out  1  high from RD_ADDR through DONE
- done  out  1  one-cycle completion pulse
- crc_out  out  DATA_WIDTH  last computed CRC, held until next job

Behaviour:
- Reset (async, HRESETn=0):
  - state=IDLE; HTRANS=IDLE; HWRITE=0; HADDR=0; HWDATA=0.
  - busy=0; done=0; crc_out=0; regs_ready edge register=0.
  - Reset mid-job aborts with no further bus activity.
- Trigger: regs_ready=1 and registered previous regs_ready=0, sampled in IDLE.
  - On trigger: capture dadr into ptr, cadr, dlen; crc=CRC_INIT; cnt=0.
  - Edges arriving outside IDLE are dropped, not queued.
  - A level held high does not retrigger.
- Bus outputs decode from registered state/ptr/crc only. No combinational path from HREADY/HRDATA to outputs.
- FSM:
  - IDLE: HTRANS=IDLE; on trigger -> RD_ADDR.
  - RD_ADDR: HTRANS=NONSEQ, HWRITE=0, HADDR=ptr. HREADY=1 -> RD_DATA; else hold with outputs stable.
  - RD_DATA: HTRANS=IDLE. HREADY=0 -> hold. HREADY=1 -> crc=next(crc,HRDATA); ptr=ptr+1 mod 2^ADDR_WIDTH; cnt=cnt+1. Then -> WR_ADDR if cnt==dlen before increment, else -> RD_ADDR.
  - WR_ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=cadr. HREADY=1 -> WR_DATA.
  - WR_DATA: HTRANS=IDLE, HWRITE=0, HWDATA=final CRC. HREADY=1 -> DONE, crc_out=final CRC.
  - DONE: done=1 for exactly one cycle -> IDLE.
- CRC arithmetic:
  - next(): DATA_WIDTH serial steps per word, MSB of HRDATA first.
  - Each step: fb = crc[MSB]^bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
  - Evaluated combinationally within one cycle. No reflection.
- Latency with zero wait states, N=dlen+1, trigger cycle = 0:
  - read k occupies cycles 2k+1 and 2k+2;
  - WR_ADDR at 2N+1, WR_DATA at 2N+2, done at 2N+3.
  - Every HREADY-low cycle adds exactly one cycle.
- Address wrap: ptr wraps 2^ADDR_WIDTH-1 -> 0.
- dadr/cadr/dlen changes after the trigger have no effect on the running job.

Optional Feature:
- Macro: CRC_FINAL_XOR_EN.
- Defined: value written in WR_DATA and loaded into crc_out is the CRC XOR all-ones (16'hFFFF for default width).
- Undefined: raw CRC register is written and reported.

Test Plan:
- Reset: assert HRESETn=0 mid-RD_DATA -> HTRANS=00, busy=0, done=0, crc_out=0 immediately. After release, no bus activity until a new regs_ready edge.
- Single word: dadr=0x05, cadr=0x20, dlen=0, HRDATA=0x0000, HREADY=1 -> NONSEQ read at 0x05 cycle 1; NONSEQ write at 0x20 cycle 3 with HWDATA=0x1D0F; done=1 cycle 5; crc_out=0x1D0F. With CRC_FINAL_XOR_EN: 0xE2F0.
- Wrap: dadr=0x3E, dlen=3 -> reads at 0x3E, 0x3F, 0x00, 0x01 in order; done at cycle 11.
- Wait states: HREADY=0 for 3 cycles during first RD_DATA -> HTRANS/HADDR stable; no CRC update; done at cycle 8 for dlen=0.
- Trigger filtering: regs_ready pulsed again during busy, then held high through DONE -> exactly one job executes, exactly one done pulse.
- Input isolation: change dadr/cadr/dlen one cycle after trigger -> addresses, count and CRC match the captured values.

Source files
------------

// File: rtl/crc_ahb_engine_if.sv
// AHB-Lite single-transfer bus between the CRC engine (master) and memory (slave).
// Latency: none, wires only.
// Backpressure: HREADY from the slave stalls the master's current phase.
//
// Signals:
//   HADDR  - word address, driven by master
//   HTRANS - IDLE (2'b00) or NONSEQ (2'b10), driven by master
//   HWRITE - write strobe for the address phase, driven by master
//   HWDATA - write data for the data phase, driven by master
//   HRDATA - read data for the data phase, driven by slave
//   HREADY - transfer complete / wait, driven by slave
interface crc_ahb_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;

  modport master (
    output HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY
  );
endinterface

// File: rtl/crc_ahb_engine.sv
// CRC engine: on a regs_ready rising edge reads dlen+1 words over AHB-Lite, folds them into a CRC, writes the result to cadr.
// Latency: with N = dlen+1 and no wait states, done pulses 2N+3 cycles after the trigger cycle.
// Backpressure: every HREADY-low cycle stalls the current phase by one cycle with bus outputs held stable.
//
// Ports:
//   HCLK, HRESETn          - clock, asynchronous active-low reset
//   regs_ready             - level from the request synchroniser; rising edge in IDLE starts a job
//   dadr, cadr, dlen       - first data address, result address, word count minus one (captured at trigger)
//   ahb (master modport)   - AHB-Lite master bus
//   busy                   - high from the first read address phase through DONE
//   done                   - one-cycle completion pulse
//   crc_out                - final CRC of the last job, held until the next job completes
//
// Optional build macro CRC_FINAL_XOR_EN: when defined, the written and reported CRC is
// inverted (XOR all-ones); otherwise the raw CRC register is used.
module crc_ahb_engine #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] CRC_POLY   = 16'h1021,
  parameter logic [DATA_WIDTH-1:0] CRC_INIT   = 16'hFFFF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  regs_ready,
  input  logic [ADDR_WIDTH-1:0] dadr,
  input  logic [ADDR_WIDTH-1:0] cadr,
  input  logic [1:0]            dlen,
  crc_ahb_engine_if.master      ahb,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] crc_out
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef CRC_FINAL_XOR_EN
  localparam logic [DATA_WIDTH-1:0] FINAL_XOR = {DATA_WIDTH{1'b1}};
`else
  localparam logic [DATA_WIDTH-1:0] FINAL_XOR = {DATA_WIDTH{1'b0}};
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  rdy_q;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cadr_q, cadr_d;
  logic [1:0]            dlen_q, dlen_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] crc_q, crc_d;
  logic [DATA_WIDTH-1:0] crc_out_q, crc_out_d;

  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;

  logic                  trig;
  logic [DATA_WIDTH-1:0] crc_final;

  // Bit-serial MSB-first CRC over one whole word, unrolled into a single cycle.
  function automatic logic [DATA_WIDTH-1:0] crc_next(
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  fb;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = r[DATA_WIDTH-1] ^ d[i];
      r  = {r[DATA_WIDTH-2:0], 1'b0} ^ ({DATA_WIDTH{fb}} & CRC_POLY);
    end
    return r;
  endfunction

  // The edge register tracks regs_ready in every state, so an edge seen while
  // busy is consumed there and a level still high on return to IDLE is ignored.
  assign trig      = regs_ready & ~rdy_q;
  assign crc_final = crc_q ^ FINAL_XOR;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      ptr_q     <= '0;
      cadr_q    <= '0;
      dlen_q    <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= regs_ready;
      ptr_q     <= ptr_d;
      cadr_q    <= cadr_d;
      dlen_q    <= dlen_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  // Bus outputs depend only on registered state; HREADY/HRDATA steer next state only.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cadr_d    = cadr_q;
    dlen_d    = dlen_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    haddr     = '0;
    htrans    = HTRANS_IDLE;
    hwrite    = 1'b0;
    hwdata    = '0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = RD_ADDR;
          ptr_d   = dadr;
          cadr_d  = cadr;
          dlen_d  = dlen;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
      end

      RD_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = ptr_q;
        if (ahb.HREADY) state_d = RD_DATA;
      end

      RD_DATA: begin
        // Address held at ptr so the bus stays stable across wait states.
        haddr = ptr_q;
        if (ahb.HREADY) begin
          crc_d   = crc_next(crc_q, ahb.HRDATA);
          ptr_d   = ptr_q + PTR_ONE;
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == dlen_q) ? WR_ADDR : RD_ADDR;
        end
      end

      WR_ADDR: begin
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = cadr_q;
        hwdata = crc_final;
        if (ahb.HREADY) state_d = WR_DATA;
      end

      WR_DATA: begin
        haddr  = cadr_q;
        hwdata = crc_final;
        if (ahb.HREADY) begin
          state_d   = DONE;
          crc_out_d = crc_final;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ahb.HADDR  = haddr;
  assign ahb.HTRANS = htrans;
  assign ahb.HWRITE = hwrite;
  assign ahb.HWDATA = hwdata;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign crc_out = crc_out_q;

endmodule

// File: tb/tb_crc_ahb_engine.sv
module tb_crc_ahb_engine;
  localparam int DW = 16;
  localparam int AW = 6;

`ifdef CRC_FINAL_XOR_EN
  localparam logic [DW-1:0] XMASK = 16'hFFFF;
`else
  localparam logic [DW-1:0] XMASK = 16'h0000;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          regs_ready = 1'b0;
  logic [AW-1:0] dadr = '0;
  logic [AW-1:0] cadr = '0;
  logic [1:0]    dlen = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] crc_out;

  crc_ahb_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  crc_ahb_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .regs_ready (regs_ready),
    .dadr       (dadr),
    .cadr       (cadr),
    .dlen       (dlen),
    .ahb        (bus.master),
    .busy       (busy),
    .done       (done),
    .crc_out    (crc_out)
  );

  always #5 HCLK = ~HCLK;

  // Memory slave: data phase returns the word addressed in the accepted address phase.
  logic [DW-1:0] mem [0:63];
  logic [AW-1:0] dph_addr = '0;
  logic          hready_drv = 1'b1;

  always @(posedge HCLK)
    if (bus.HTRANS == 2'b10 && bus.HREADY) dph_addr <= bus.HADDR;

  assign bus.HRDATA = mem[dph_addr];
  assign bus.HREADY = hready_drv;

  // Per-cycle log, index = cycles after the trigger cycle.
  logic [1:0]    lt  [0:31];
  logic [AW-1:0] la  [0:31];
  logic          lw  [0:31];
  logic [DW-1:0] ld  [0:31];
  logic          ldn [0:31];
  logic          lb  [0:31];

  int wait_at  = -1;
  int wait_len = 0;
  int hook     = 0;  // 1: change inputs after trigger, 2: extra regs_ready activity
  int checks   = 0;
  int passes   = 0;

  // Starts at #1 after a rising edge with the engine idle and regs_ready low.
  task automatic run_job(input logic [AW-1:0] da, input logic [AW-1:0] ca,
                         input logic [1:0] dl, input int ncyc);
    dadr = da; cadr = ca; dlen = dl;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge HCLK); #1;
      end
      hready_drv = !(c >= wait_at && c < wait_at + wait_len);
      if (hook == 2) regs_ready = (c == 0) || (c == 2) || (c >= 4 && c < 12);
      else           regs_ready = (c == 0);
      if (hook == 1 && c == 1) begin
        dadr = 6'h00; cadr = 6'h00; dlen = 2'd3;
      end
      lt[c] = bus.HTRANS; la[c] = bus.HADDR; lw[c] = bus.HWRITE;
      ld[c] = bus.HWDATA; ldn[c] = done;     lb[c] = busy;
    end
    regs_ready = 1'b0; hready_drv = 1'b1; wait_at = -1; wait_len = 0; hook = 0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.HTRANS !== 2'b00) $display("FAIL reset_htrans: got %b want 00", bus.HTRANS); else passes++;
    checks++; if (bus.HWRITE !== 1'b0) $display("FAIL reset_hwrite: got %b want 0", bus.HWRITE); else passes++;
    checks++; if (bus.HADDR !== 6'h00) $display("FAIL reset_haddr: got %h want 00", bus.HADDR); else passes++;
    checks++; if (bus.HWDATA !== 16'h0000) $display("FAIL reset_hwdata: got %h want 0000", bus.HWDATA); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (crc_out !== 16'h0000) $display("FAIL reset_crc_out: got %h want 0000", crc_out); else passes++;
    #5 HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_single_word();
    int n;
    mem[6'h05] = 16'h0000;
    run_job(6'h05, 6'h20, 2'd0, 10);
    checks++; if ({lt[1], lw[1], la[1]} !== {2'b10, 1'b0, 6'h05}) $display("FAIL single_rd_addr: got trans=%b wr=%b addr=%h want 10/0/05", lt[1], lw[1], la[1]); else passes++;
    checks++; if (lb[1] !== 1'b1) $display("FAIL single_busy: got %b want 1", lb[1]); else passes++;
    checks++; if ({lt[3], lw[3], la[3]} !== {2'b10, 1'b1, 6'h20}) $display("FAIL single_wr_addr: got trans=%b wr=%b addr=%h want 10/1/20", lt[3], lw[3], la[3]); else passes++;
    checks++; if ({lt[4], lw[4]} !== {2'b00, 1'b0}) $display("FAIL single_wr_data_ctl: got trans=%b wr=%b want 00/0", lt[4], lw[4]); else passes++;
    checks++; if (ld[4] !== (16'h1D0F ^ XMASK)) $display("FAIL single_hwdata: got %h want %h", ld[4], 16'h1D0F ^ XMASK); else passes++;
    n = 0;
    for (int c = 0; c < 10; c++) if (ldn[c] === 1'b1) n++;
    checks++; if (ldn[5] !== 1'b1 || n != 1) $display("FAIL single_done: got done@5=%b pulses=%0d want 1/1", ldn[5], n); else passes++;
    checks++; if (lb[6] !== 1'b0) $display("FAIL single_busy_end: got %b want 0", lb[6]); else passes++;
    checks++; if (crc_out !== (16'h1D0F ^ XMASK)) $display("FAIL single_crc_out: got %h want %h", crc_out, 16'h1D0F ^ XMASK); else passes++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [0:3];
    exp_a[0] = 6'h3E; exp_a[1] = 6'h3F; exp_a[2] = 6'h00; exp_a[3] = 6'h01;
    // FFFF -0000-> 1D0F -1D0F-> 0000 -0000-> 0000 -0001-> 1021
    mem[6'h3E] = 16'h0000; mem[6'h3F] = 16'h1D0F; mem[6'h00] = 16'h0000; mem[6'h01] = 16'h0001;
    run_job(6'h3E, 6'h10, 2'd3, 16);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({lt[2*k+1], lw[2*k+1], la[2*k+1]} !== {2'b10, 1'b0, exp_a[k]})
        $display("FAIL wrap_read%0d: got trans=%b wr=%b addr=%h want 10/0/%h", k, lt[2*k+1], lw[2*k+1], la[2*k+1], exp_a[k]);
      else passes++;
    end
    checks++; if ({lt[9], lw[9], la[9]} !== {2'b10, 1'b1, 6'h10}) $display("FAIL wrap_wr_addr: got trans=%b wr=%b addr=%h want 10/1/10", lt[9], lw[9], la[9]); else passes++;
    checks++; if (ld[10] !== (16'h1021 ^ XMASK)) $display("FAIL wrap_hwdata: got %h want %h", ld[10], 16'h1021 ^ XMASK); else passes++;
    checks++; if ({ldn[10], ldn[11], ldn[12]} !== 3'b010) $display("FAIL wrap_done: got done@10..12=%b want 010", {ldn[10], ldn[11], ldn[12]}); else passes++;
    checks++; if (crc_out !== (16'h1021 ^ XMASK)) $display("FAIL wrap_crc_out: got %h want %h", crc_out, 16'h1021 ^ XMASK); else passes++;
  endtask

  task automatic test_wait_states();
    // FFFF ^ FFFB = 0004 -> x^18 mod P = 4084
    mem[6'h07] = 16'hFFFB;
    wait_at = 2; wait_len = 3;
    run_job(6'h07, 6'h21, 2'd0, 12);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if ({lt[c], la[c]} !== {2'b00, 6'h07})
        $display("FAIL wait_stable_c%0d: got trans=%b addr=%h want 00/07", c, lt[c], la[c]);
      else passes++;
    end
    checks++; if ({lt[6], lw[6], la[6]} !== {2'b10, 1'b1, 6'h21}) $display("FAIL wait_wr_addr: got trans=%b wr=%b addr=%h want 10/1/21", lt[6], lw[6], la[6]); else passes++;
    checks++; if ({ldn[7], ldn[8], ldn[9]} !== 3'b010) $display("FAIL wait_done: got done@7..9=%b want 010", {ldn[7], ldn[8], ldn[9]}); else passes++;
    checks++; if (crc_out !== (16'h4084 ^ XMASK)) $display("FAIL wait_crc_out: got %h want %h", crc_out, 16'h4084 ^ XMASK); else passes++;
  endtask

  task automatic test_trigger_filter();
    int nd;
    int nt;
    // FFFF -FFFF-> 0000 -0004-> 4084
    mem[6'h08] = 16'hFFFF; mem[6'h09] = 16'h0004;
    hook = 2;
    run_job(6'h08, 6'h22, 2'd1, 20);
    nd = 0; nt = 0;
    for (int c = 0; c < 20; c++) begin
      if (ldn[c] === 1'b1) nd++;
      if (lt[c] === 2'b10) nt++;
    end
    checks++; if (ldn[7] !== 1'b1 || nd != 1) $display("FAIL filter_done: got done@7=%b pulses=%0d want 1/1", ldn[7], nd); else passes++;
    checks++; if (nt != 3) $display("FAIL filter_nonseq: got %0d transfers want 3", nt); else passes++;
    checks++; if (lb[15] !== 1'b0) $display("FAIL filter_idle: got busy=%b want 0", lb[15]); else passes++;
    checks++; if (crc_out !== (16'h4084 ^ XMASK)) $display("FAIL filter_crc_out: got %h want %h", crc_out, 16'h4084 ^ XMASK); else passes++;
  endtask

  task automatic test_input_isolation();
    // FFFF ^ FFFE = 0001 -> 1021; 1021 ^ 1023 = 0002 -> 2042
    mem[6'h10] = 16'hFFFE; mem[6'h11] = 16'h1023;
    mem[6'h00] = 16'h1234;
    hook = 1;
    run_job(6'h10, 6'h30, 2'd1, 12);
    checks++; if ({lt[1], la[1]} !== {2'b10, 6'h10}) $display("FAIL iso_read0: got trans=%b addr=%h want 10/10", lt[1], la[1]); else passes++;
    checks++; if ({lt[3], lw[3], la[3]} !== {2'b10, 1'b0, 6'h11}) $display("FAIL iso_read1: got trans=%b wr=%b addr=%h want 10/0/11", lt[3], lw[3], la[3]); else passes++;
    checks++; if ({lt[5], lw[5], la[5]} !== {2'b10, 1'b1, 6'h30}) $display("FAIL iso_wr_addr: got trans=%b wr=%b addr=%h want 10/1/30", lt[5], lw[5], la[5]); else passes++;
    checks++; if ({ldn[6], ldn[7], ldn[8]} !== 3'b010) $display("FAIL iso_done: got done@6..8=%b want 010", {ldn[6], ldn[7], ldn[8]}); else passes++;
    checks++; if (crc_out !== (16'h2042 ^ XMASK)) $display("FAIL iso_crc_out: got %h want %h", crc_out, 16'h2042 ^ XMASK); else passes++;
  endtask

  task automatic test_reset_midjob();
    dadr = 6'h05; cadr = 6'h20; dlen = 2'd0; regs_ready = 1'b1;
    @(posedge HCLK); #1;
    regs_ready = 1'b0;
    @(posedge HCLK); #1;
    checks++; if ({lt[0], busy, bus.HTRANS} !== {lt[0], 1'b1, 2'b00}) $display("FAIL midjob_pre: got busy=%b trans=%b want 1/00", busy, bus.HTRANS); else passes++;
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (bus.HTRANS !== 2'b00) $display("FAIL midjob_htrans: got %b want 00", bus.HTRANS); else passes++;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL midjob_busy_done: got %b want 00", {busy, done}); else passes++;
    checks++; if (crc_out !== 16'h0000) $display("FAIL midjob_crc_out: got %h want 0000", crc_out); else passes++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge HCLK); #1;
      checks++;
      if ({bus.HTRANS, busy} !== 3'b000)
        $display("FAIL post_reset_idle_c%0d: got trans=%b busy=%b want 00/0", c, bus.HTRANS, busy);
      else passes++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_single_word();
    test_wrap();
    test_wait_states();
    test_trigger_filter();
    test_input_isolation();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
